// File: rtl/mesi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mesi_bus_ctrl
// Brief    : Snooping-bus arbiter/sequencer for four MESI caches with DRAM
//            fill and flush write-back.
// Revision : 1.0
// ============================================================================
module mesi_bus_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int N_CACHE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_CACHE-1:0]         BusRd_req,
    input  logic [N_CACHE-1:0]         BusRdX_req,
    input  logic [N_CACHE-1:0]         BusUpgr_req,
    input  logic [N_CACHE*ADDR_W-1:0]  addr_req,
    input  logic [N_CACHE-1:0]         C_rsp,
    input  logic [N_CACHE-1:0]         Flush_rsp,
    input  logic                       mem_ack,
    output logic [N_CACHE-1:0]         grant,
    output logic [N_CACHE-1:0]         done,
    output logic                       C_to_req,
    output logic                       BusRd_snp,
    output logic                       BusRdX_snp,
    output logic                       BusUpgr_snp,
    output logic [N_CACHE-1:0]         snp_mask,
    output logic [ADDR_W-1:0]          snp_addr,
    output logic                       mem_rd_req,
    output logic                       mem_wr_req
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SNOOP = 3'd1,
        S_RESP  = 3'd2,
        S_WB    = 3'd3,
        S_MEM   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        T_RD   = 2'd0,
        T_RDX  = 2'd1,
        T_UPGR = 2'd2
    } txn_t;

    state_t             r_state;
    txn_t               r_type;
    logic [1:0]         r_rr;
    logic [1:0]         r_owner;
    logic               r_skip;
    logic               r_shared;

    logic [ADDR_W-1:0]  w_addr_slot [N_CACHE];
    logic [N_CACHE-1:0] w_req;
    logic [N_CACHE-1:0] w_elig;
    logic [N_CACHE-1:0] w_owner_oh;
    logic [N_CACHE-1:0] w_win_oh;
    logic [1:0]         w_idx;
    logic [1:0]         w_win;
    logic               w_found;
    txn_t               w_type;
    logic               w_shared;
    logic               w_flush;

    function automatic logic [N_CACHE-1:0] f_onehot(input logic [1:0] idx);
        logic [N_CACHE-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < N_CACHE; gi++) begin : g_addr_slot
            assign w_addr_slot[gi] = addr_req[gi*ADDR_W +: ADDR_W];
        end
    endgenerate

    assign w_owner_oh = f_onehot(r_owner);
    assign w_win_oh   = f_onehot(w_win);
    // Snoop results exclude the owner's own response lines.
    assign w_shared   = |(C_rsp & ~w_owner_oh);
    assign w_flush    = |(Flush_rsp & ~w_owner_oh);

    // Round-robin scan starting at r_rr; the previous owner sits out one cycle.
    always_comb begin
        w_req   = BusRd_req | BusRdX_req | BusUpgr_req;
        w_elig  = w_req & ~(r_skip ? w_owner_oh : '0);
        w_found = 1'b0;
        w_win   = r_rr;
        w_idx   = '0;
        for (int k = 0; k < N_CACHE; k++) begin
            w_idx = r_rr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        if (BusRdX_req[w_win])
            w_type = T_RDX;
        else if (BusUpgr_req[w_win])
            w_type = T_UPGR;
        else
            w_type = T_RD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_type      <= T_RD;
            r_rr        <= '0;
            r_owner     <= '0;
            r_skip      <= 1'b0;
            r_shared    <= 1'b0;
            grant       <= '0;
            done        <= '0;
            C_to_req    <= 1'b0;
            BusRd_snp   <= 1'b0;
            BusRdX_snp  <= 1'b0;
            BusUpgr_snp <= 1'b0;
            snp_mask    <= '0;
            snp_addr    <= '0;
            mem_rd_req  <= 1'b0;
            mem_wr_req  <= 1'b0;
        end else begin
            done        <= '0;
            C_to_req    <= 1'b0;
            BusRd_snp   <= 1'b0;
            BusRdX_snp  <= 1'b0;
            BusUpgr_snp <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_skip <= 1'b0;
                    if (w_found) begin
                        r_owner     <= w_win;
                        r_type      <= w_type;
                        snp_addr    <= w_addr_slot[w_win];
                        grant       <= w_win_oh;
                        snp_mask    <= ~w_win_oh;
                        BusRd_snp   <= (w_type == T_RD);
                        BusRdX_snp  <= (w_type == T_RDX);
                        BusUpgr_snp <= (w_type == T_UPGR);
                        r_state     <= S_SNOOP;
                    end
                end
                S_SNOOP: begin
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    snp_mask <= '0;
                    r_shared <= w_shared;
                    if (r_type == T_UPGR) begin
                        done    <= w_owner_oh;
                        r_state <= S_DONE;
                    end else if (w_flush) begin
                        // The flushed line is the fill data, so no DRAM read.
                        mem_wr_req <= 1'b1;
                        r_state    <= S_WB;
                    end else begin
                        mem_rd_req <= 1'b1;
                        r_state    <= S_MEM;
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        mem_wr_req <= 1'b0;
                        done       <= w_owner_oh;
                        C_to_req   <= (r_type == T_RD) && r_shared;
                        r_state    <= S_DONE;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_rd_req <= 1'b0;
                        done       <= w_owner_oh;
                        C_to_req   <= (r_type == T_RD) && r_shared;
                        r_state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    grant   <= '0;
                    r_rr    <= r_owner + 2'd1;
                    r_skip  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mesi_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mesi_bus_ctrl
// Brief    : Self-checking bench for mesi_bus_ctrl: directed scenarios plus
//            randomized traffic against a transaction-level arbitration model.
// Revision : 1.0
// ============================================================================
module tb_mesi_bus_ctrl;

    localparam int c_rd   = 0;
    localparam int c_rdx  = 1;
    localparam int c_upgr = 2;

    logic        clk;
    logic        rst;
    logic [3:0]  BusRd_req;
    logic [3:0]  BusRdX_req;
    logic [3:0]  BusUpgr_req;
    logic [127:0] addr_req;
    logic [3:0]  C_rsp;
    logic [3:0]  Flush_rsp;
    logic        mem_ack;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        C_to_req;
    logic        BusRd_snp;
    logic        BusRdX_snp;
    logic        BusUpgr_snp;
    logic [3:0]  snp_mask;
    logic [31:0] snp_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    // Reference model state: pending request per cache (-1 = none).
    int          p_type [4];
    logic [31:0] p_addr [4];
    int          m_rr    = 0;
    int          m_prev  = -1;
    bit          m_first = 1'b0;

    mesi_bus_ctrl #(.ADDR_W(32), .N_CACHE(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .BusRd_req   (BusRd_req),
        .BusRdX_req  (BusRdX_req),
        .BusUpgr_req (BusUpgr_req),
        .addr_req    (addr_req),
        .C_rsp       (C_rsp),
        .Flush_rsp   (Flush_rsp),
        .mem_ack     (mem_ack),
        .grant       (grant),
        .done        (done),
        .C_to_req    (C_to_req),
        .BusRd_snp   (BusRd_snp),
        .BusRdX_snp  (BusRdX_snp),
        .BusUpgr_snp (BusUpgr_snp),
        .snp_mask    (snp_mask),
        .snp_addr    (snp_addr),
        .mem_rd_req  (mem_rd_req),
        .mem_wr_req  (mem_wr_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [17:0] f_obs(input bit with_mask);
        return {grant, done, C_to_req, BusRd_snp, BusRdX_snp, BusUpgr_snp,
                with_mask ? snp_mask : 4'b0000, mem_rd_req, mem_wr_req};
    endfunction

    function automatic logic [17:0] f_exp(input logic [3:0] g, input logic [3:0] d, input bit c,
                                          input bit rd, input bit rdx, input bit up,
                                          input logic [3:0] m, input bit mr, input bit mw);
        return {g, d, c, rd, rdx, up, m, mr, mw};
    endfunction

    task automatic set_req(input int i, input logic [2:0] bits, input logic [31:0] a);
        BusRd_req[i]          = bits[0];
        BusRdX_req[i]         = bits[1];
        BusUpgr_req[i]        = bits[2];
        addr_req[i*32 +: 32]  = a;
    endtask

    // Drives one whole transaction from the IDLE cycle in which `win` must win.
    task automatic txn(input int win, input int ty, input logic [31:0] a, input logic [3:0] c,
                       input logic [3:0] f, input int wait_n, input bit drop);
        logic [3:0]  oh;
        logic [31:0] saved;
        logic        sh;
        logic        fl;
        int          lat;
        oh  = 4'b0001 << win;
        sh  = |(c & ~oh);
        fl  = |(f & ~oh);
        lat = (ty == c_upgr) ? 4 : 5 + wait_n;
        cyc = 1;
        chk("idle", f_obs(1), 0);
        tick;
        chk("snoop", f_obs(1), f_exp(oh, 4'b0, 1'b0, ty == c_rd, ty == c_rdx, ty == c_upgr, ~oh, 1'b0, 1'b0));
        chk("snp_addr", snp_addr, a);
        saved = addr_req[win*32 +: 32];
        addr_req[win*32 +: 32] = $urandom;
        mem_ack = 1'($urandom);
        tick;
        chk("resp", f_obs(0), f_exp(oh, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0));
        C_rsp     = c;
        Flush_rsp = f;
        mem_ack   = 1'($urandom);
        tick;
        C_rsp     = 4'b0;
        Flush_rsp = 4'b0;
        if (ty != c_upgr) begin
            for (int i = 0; i <= wait_n; i++) begin
                chk(fl ? "wb_wait" : "mem_wait", f_obs(0),
                    f_exp(oh, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, !fl, fl));
                mem_ack = (i == wait_n);
                tick;
            end
        end
        chk("done", f_obs(0), f_exp(oh, oh, (ty == c_rd) && sh, 1'b0, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0));
        chk("latency", cyc, lat);
        chk("snp_addr_hold", snp_addr, a);
        addr_req[win*32 +: 32] = saved;
        if (drop)
            set_req(win, 3'b000, $urandom);
        mem_ack = 1'($urandom);
        tick;
        mem_ack = 1'b0;
    endtask

    function automatic int f_pick(input bit use_mask);
        int w;
        int cc;
        w = -1;
        for (int k = 0; k < 4; k++) begin
            cc = (m_rr + k) % 4;
            if (w < 0 && p_type[cc] >= 0 && !(use_mask && cc == m_prev))
                w = cc;
        end
        return w;
    endfunction

    initial begin
        logic [2:0]  bits;
        logic [31:0] a;
        int          win;
        bit          any;

        rst = 1'b1;
        BusRd_req = 4'b0; BusRdX_req = 4'b0; BusUpgr_req = 4'b0;
        addr_req = '0; C_rsp = 4'b0; Flush_rsp = 4'b0; mem_ack = 1'b0;
        tick;
        tick;
        chk("reset_out", f_obs(1), 0);
        chk("reset_addr", snp_addr, 0);
        rst = 1'b0;

        // Plain read miss: cache 2, no snoop hits.
        set_req(2, 3'b001, 32'h40);
        txn(2, c_rd, 32'h40, 4'b0000, 4'b0000, 0, 1'b1);
        // Read with a dirty copy in cache 3: flush path, shared result.
        set_req(0, 3'b001, 32'h80);
        txn(0, c_rd, 32'h80, 4'b1000, 4'b1000, 1, 1'b1);
        // Upgrade: no DRAM traffic, 4-cycle latency.
        set_req(1, 3'b100, 32'hC0);
        txn(1, c_upgr, 32'hC0, 4'b0000, 4'b0000, 0, 1'b1);
        // Owner's own responses are ignored.
        set_req(3, 3'b001, 32'h100);
        txn(3, c_rd, 32'h100, 4'b1000, 4'b1000, 0, 1'b1);
        // Multi-bit type priority with two requesters.
        set_req(0, 3'b101, 32'h200);
        set_req(2, 3'b111, 32'h240);
        txn(0, c_upgr, 32'h200, 4'b0100, 4'b0000, 0, 1'b1);
        txn(2, c_rdx, 32'h240, 4'b0001, 4'b0000, 2, 1'b1);

        // Continuous BusRdX from all caches: rotation 0,1,2,3,0.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            set_req(i, 3'b010, 32'h1000 + 32'(i) * 32'h40);
        for (int k = 0; k < 5; k++)
            txn(k % 4, c_rdx, 32'h1000 + 32'(k % 4) * 32'h40, 4'b0000, 4'b0000, 0, 1'b0);

        // Abort cache 1's fill with reset while mem_ack is withheld.
        chk("pre_abort_idle", f_obs(1), 0);
        tick;
        tick;
        mem_ack = 1'b0;
        tick;
        chk("abort_mem", f_obs(0), f_exp(4'b0010, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1, 1'b0));
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out", f_obs(1), 0);
        chk("abort_addr", snp_addr, 0);
        tick;
        rst = 1'b0;
        txn(0, c_rdx, 32'h1000, 4'b0000, 4'b0000, 0, 1'b1);
        for (int i = 1; i < 4; i++)
            set_req(i, 3'b000, 32'h0);
        rst = 1'b1;
        tick;
        rst = 1'b0;

        // Randomized traffic against the arbitration model.
        for (int i = 0; i < 4; i++) begin
            p_type[i] = -1;
            p_addr[i] = '0;
        end
        m_rr = 0; m_prev = -1; m_first = 1'b0;
        for (int t = 0; t < 40; t++) begin
            any = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (p_type[i] < 0 && $urandom_range(0, 1) == 1) begin
                    bits = 3'($urandom_range(1, 7));
                    a    = $urandom;
                    set_req(i, bits, a);
                    p_type[i] = bits[1] ? c_rdx : (bits[2] ? c_upgr : c_rd);
                    p_addr[i] = a;
                end
                if (p_type[i] >= 0)
                    any = 1'b1;
            end
            if (!any) begin
                win = $urandom_range(0, 3);
                a   = $urandom;
                set_req(win, 3'b001, a);
                p_type[win] = c_rd;
                p_addr[win] = a;
            end
            win = f_pick(m_first);
            if (win < 0) begin
                chk("masked_idle", f_obs(1), 0);
                tick;
                win = f_pick(1'b0);
            end
            txn(win, p_type[win], p_addr[win], 4'($urandom), 4'($urandom & $urandom),
                $urandom_range(0, 3), 1'b1);
            p_type[win] = -1;
            m_rr        = (win + 1) % 4;
            m_prev      = win;
            m_first     = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
